inject_arbiter: RTL and testbench

INJECT_ARBITER -- requirements
Module: inject_arbiter

---
 rtl/PhiversPkg.sv | 10 +
 rtl/rr_arbiter.sv | 9 +
 rtl/inject_arbiter.sv | 65 ++++++
 tb/tb_inject_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/PhiversPkg.sv
// PhiversPkg: shared FSM states, packet field positions and grant encodings
// for the injection-port arbiter.
package PhiversPkg;
  typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} inject_state_t;
  localparam int HEADER_IDX = 0;
  localparam int SIZE_IDX = 1;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_MA = 2'b01;
  localparam logic [1:0] GNT_APP = 2'b10;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: two-input round-robin arbiter; on a tie the source not granted
// last wins (last: 0 = management, 1 = application).
module rr_arbiter (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt = {req[1] & (~req[0] | ~last), req[0] & (~req[1] | last)};
endmodule

// File: rtl/inject_arbiter.sv
// inject_arbiter: packet-level arbiter sharing one injection port between a
// management and an application source; the grant is held for a whole packet.
module inject_arbiter
  import PhiversPkg::*;
#(
  parameter int FLIT_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ma_rx_i,
  output logic                 ma_credit_o,
  input  logic [FLIT_SIZE-1:0] ma_data_i,
  input  logic                 app_rx_i,
  output logic                 app_credit_o,
  input  logic [FLIT_SIZE-1:0] app_data_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic [1:0]           grant_o
);
  inject_state_t state;
  logic [FLIT_SIZE-1:0] cnt;
  logic last;
  logic [1:0] winner;
  logic xfer;
  rr_arbiter u_rr (.req({app_rx_i, ma_rx_i}), .last(last), .gnt(winner));
  // grant_o is 00 whenever idle or in reset, so the mux alone silences the port
  always_comb begin
    tx_o = (grant_o[0] & ma_rx_i) | (grant_o[1] & app_rx_i);
    data_o = grant_o[0] ? ma_data_i : grant_o[1] ? app_data_i : '0;
    ma_credit_o = grant_o[0] & credit_i;
    app_credit_o = grant_o[1] & credit_i;
  end
  assign xfer = tx_o & credit_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      grant_o <= GNT_NONE;
      last <= 1'b1;
    end else begin
      case (state)
        IDLE: if (|winner) begin
          grant_o <= winner;
          last <= winner[1];
          state <= HEADER;
        end
        HEADER: if (xfer) state <= SIZE;
        SIZE: if (xfer) begin
          cnt <= data_o;
          state <= |data_o ? PAYLOAD : IDLE;
          if (~|data_o) grant_o <= GNT_NONE;
        end
        PAYLOAD: if (xfer) begin
          cnt <= cnt - FLIT_SIZE'(1);
          if (cnt == FLIT_SIZE'(1)) begin
            state <= IDLE;
            grant_o <= GNT_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inject_arbiter.sv
// tb_inject_arbiter: randomized packet traffic from both sources, checked
// against a packet-level round-robin model of the expected injection stream.
module tb_inject_arbiter;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ma_rx, ma_credit, app_rx, app_credit, tx, credit;
  logic [W-1:0] ma_data, app_data, data;
  logic [1:0] grant;

  inject_arbiter #(.FLIT_SIZE(W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ma_rx_i(ma_rx), .ma_credit_o(ma_credit), .ma_data_i(ma_data),
    .app_rx_i(app_rx), .app_credit_o(app_credit), .app_data_i(app_data),
    .tx_o(tx), .credit_i(credit), .data_o(data), .grant_o(grant)
  );

  always #5 clk = ~clk;

  // bit W marks a header flit
  logic [W:0] ma_q[$], app_q[$], mod_ma[$], mod_app[$];
  logic [1:0] exp_g[$], obs_g[$];
  logic [W-1:0] exp_d[$], obs_d[$];
  int obs_c[$];
  int n_checks = 0, n_fail = 0, cyc = 0, bad_credit = 0;
  int rx_pct = 100, cr_pct = 100;
  logic model_last = 1'b1;

  task automatic clear();
    ma_q.delete(); app_q.delete(); mod_ma.delete(); mod_app.delete();
    exp_g.delete(); exp_d.delete(); obs_g.delete(); obs_d.delete(); obs_c.delete();
    cyc = 0; bad_credit = 0;
  endtask

  task automatic add_pkt(input bit src, input logic [W-1:0] hdr, input int n, input logic [W-1:0] base);
    logic [W:0] f[$];
    f.push_back({1'b1, hdr});
    f.push_back({1'b0, W'(n)});
    for (int i = 0; i < n; i++) f.push_back({1'b0, base + W'(i)});
    foreach (f[i]) begin
      if (src) begin app_q.push_back(f[i]); mod_app.push_back(f[i]); end
      else begin ma_q.push_back(f[i]); mod_ma.push_back(f[i]); end
    end
  endtask

  // whole packets in round-robin order; a tie goes to the source not served last
  task automatic build_expected();
    logic [W:0] f;
    bit pick_app, more;
    while (mod_ma.size() != 0 || mod_app.size() != 0) begin
      pick_app = (mod_ma.size() != 0 && mod_app.size() != 0) ? !model_last : (mod_app.size() != 0);
      model_last = pick_app;
      do begin
        f = pick_app ? mod_app.pop_front() : mod_ma.pop_front();
        exp_g.push_back(pick_app ? 2'b10 : 2'b01);
        exp_d.push_back(f[W-1:0]);
        more = pick_app ? (mod_app.size() != 0 && !mod_app[0][W]) : (mod_ma.size() != 0 && !mod_ma[0][W]);
      end while (more);
    end
  endtask

  // one clock: headers are always offered so a pending packet always requests
  task automatic step();
    ma_rx = 1'b0; app_rx = 1'b0; ma_data = '0; app_data = '0;
    if (ma_q.size() != 0) begin
      ma_data = ma_q[0][W-1:0];
      ma_rx = ma_q[0][W] || ($urandom_range(99) < rx_pct);
    end
    if (app_q.size() != 0) begin
      app_data = app_q[0][W-1:0];
      app_rx = app_q[0][W] || ($urandom_range(99) < rx_pct);
    end
    credit = $urandom_range(99) < cr_pct;
    #2;
    if ((ma_credit && !(grant == 2'b01 && credit)) || (app_credit && !(grant == 2'b10 && credit))) bad_credit++;
    if (tx && credit) begin obs_g.push_back(grant); obs_d.push_back(data); obs_c.push_back(cyc); end
    if (ma_rx && ma_credit) void'(ma_q.pop_front());
    if (app_rx && app_credit) void'(app_q.pop_front());
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(input int budget, output bit timeout);
    int n = 0;
    do begin step(); n++; end
    while ((ma_q.size() != 0 || app_q.size() != 0 || grant != 2'b00) && n < budget);
    timeout = ma_q.size() != 0 || app_q.size() != 0 || grant != 2'b00;
  endtask

  task automatic test_reset();
    ma_rx = 1'b1; app_rx = 1'b1; credit = 1'b1; ma_data = 'h11; app_data = 'h22;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_checks++; if (tx !== 1'b0 || ma_credit !== 1'b0 || app_credit !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs: got tx=%b mc=%b ac=%b want 0 0 0", tx, ma_credit, app_credit); end
    n_checks++; if (data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data); end
    ma_rx = 1'b0; app_rx = 1'b0; credit = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL idle_grant: got %b want 00", grant); end
  endtask

  task automatic test_tie();
    bit to;
    clear(); rx_pct = 100; cr_pct = 100;
    add_pkt(0, 'h1000, 3, 'h10);
    add_pkt(1, 'h2000, 3, 'h20);
    build_expected();
    run(100, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL tie_timeout: got busy want idle"); end
    n_checks++; if (obs_g.size() == 0 || obs_g[0] !== 2'b01) begin n_fail++; $display("FAIL tie_first: got %b want 01", obs_g.size() ? obs_g[0] : 2'bxx); end
    n_checks++; if (bad_credit != 0) begin n_fail++; $display("FAIL tie_credit: got %0d stray credits want 0", bad_credit); end
    n_checks++; if (obs_d.size() != exp_d.size()) begin n_fail++; $display("FAIL tie_len: got %0d want %0d", obs_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      n_checks++;
      if (obs_d[i] !== exp_d[i] || obs_g[i] !== exp_g[i]) begin
        n_fail++; $display("FAIL tie_flit[%0d]: got g=%b d=%h want g=%b d=%h", i, obs_g[i], obs_d[i], exp_g[i], exp_d[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int trans = 0, bad_gap = 0;
    clear(); rx_pct = 100; cr_pct = 100;
    for (int p = 0; p < 3; p++) begin
      add_pkt(0, W'('h100 + p), $urandom_range(4), W'('h1000 * p));
      add_pkt(1, W'('h200 + p), $urandom_range(4), W'('h2000 * p));
    end
    build_expected();
    run(300, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout: got busy want idle"); end
    for (int i = 1; i < obs_g.size(); i++) if (obs_g[i] != obs_g[i-1]) begin
      trans++;
      if (obs_c[i] - obs_c[i-1] != 2) bad_gap++;
    end
    n_checks++; if (obs_g.size() == 0 || obs_g[0] !== 2'b01) begin n_fail++; $display("FAIL b2b_first: got %b want 01", obs_g.size() ? obs_g[0] : 2'bxx); end
    n_checks++; if (trans != 5) begin n_fail++; $display("FAIL b2b_alternate: got %0d grant changes want 5", trans); end
    n_checks++; if (bad_gap != 0) begin n_fail++; $display("FAIL b2b_gap: got %0d gaps not equal to 2 want 0", bad_gap); end
    n_checks++; if (obs_d.size() != exp_d.size()) begin n_fail++; $display("FAIL b2b_len: got %0d want %0d", obs_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      n_checks++;
      if (obs_d[i] !== exp_d[i] || obs_g[i] !== exp_g[i]) begin
        n_fail++; $display("FAIL b2b_flit[%0d]: got g=%b d=%h want g=%b d=%h", i, obs_g[i], obs_d[i], exp_g[i], exp_d[i]); end
    end
  endtask

  task automatic test_single();
    bit to;
    clear(); rx_pct = 100; cr_pct = 100;
    add_pkt(0, 'h0101, 2, 'hA);
    build_expected();
    step();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_latency: got %b want 01", grant); end
    run(50, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL single_timeout: got busy want idle"); end
    n_checks++; if (obs_d.size() != 4) begin n_fail++; $display("FAIL single_len: got %0d want 4", obs_d.size()); end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      n_checks++;
      if (obs_d[i] !== exp_d[i] || obs_g[i] !== 2'b01 || obs_c[i] != i + 1) begin
        n_fail++; $display("FAIL single_flit[%0d]: got g=%b d=%h cyc=%0d want g=01 d=%h cyc=%0d", i, obs_g[i], obs_d[i], obs_c[i], exp_d[i], i + 1); end
    end
  endtask

  task automatic test_size_zero();
    bit to;
    clear(); rx_pct = 100; cr_pct = 100;
    add_pkt(0, 'h3000, 0, 0);
    add_pkt(0, 'h3100, 1, 'h31);
    build_expected();
    run(50, to);
    step();
    n_checks++; if (to) begin n_fail++; $display("FAIL zero_timeout: got busy want idle"); end
    n_checks++; if (bad_credit != 0) begin n_fail++; $display("FAIL zero_credit: got %0d stray credits want 0", bad_credit); end
    n_checks++; if (obs_c.size() < 3 || obs_c[2] - obs_c[1] != 2) begin n_fail++; $display("FAIL zero_idle: got %0d flits or no rearbitration gap want 2-cycle gap", obs_c.size()); end
    n_checks++; if (obs_d.size() != exp_d.size()) begin n_fail++; $display("FAIL zero_len: got %0d want %0d", obs_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      n_checks++;
      if (obs_d[i] !== exp_d[i] || obs_g[i] !== exp_g[i]) begin
        n_fail++; $display("FAIL zero_flit[%0d]: got g=%b d=%h want g=%b d=%h", i, obs_g[i], obs_d[i], exp_g[i], exp_d[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear(); rx_pct = 60; cr_pct = 50;
    add_pkt(1, 'h4000, 16, 'h400);
    add_pkt(0, 'h4100, 2, 'h410);
    build_expected();
    run(600, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL bp_timeout: got busy want idle"); end
    n_checks++; if (bad_credit != 0) begin n_fail++; $display("FAIL bp_credit: got %0d stray credits want 0", bad_credit); end
    n_checks++; if (obs_d.size() != exp_d.size()) begin n_fail++; $display("FAIL bp_len: got %0d want %0d", obs_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      n_checks++;
      if (obs_d[i] !== exp_d[i] || obs_g[i] !== exp_g[i]) begin
        n_fail++; $display("FAIL bp_flit[%0d]: got g=%b d=%h want g=%b d=%h", i, obs_g[i], obs_d[i], exp_g[i], exp_d[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear(); rx_pct = 100; cr_pct = 100;
    add_pkt(0, 'h5000, 8, 'h50);
    for (int n = 0; n < 60 && obs_d.size() < 5; n++) step();
    n_checks++; if (obs_d.size() != 5) begin n_fail++; $display("FAIL rmid_progress: got %0d flits want 5", obs_d.size()); end
    ma_rx = 1'b1; credit = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b0 || ma_credit !== 1'b0 || app_credit !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async: got tx=%b mc=%b ac=%b want 0 0 0", tx, ma_credit, app_credit); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rmid_grant: got %b want 00", grant); end
    clear(); model_last = 1'b1;
    ma_rx = 1'b0; app_rx = 1'b0; credit = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    add_pkt(1, 'h6100, 1, 'h61);
    add_pkt(0, 'h6000, 1, 'h60);
    build_expected();
    run(100, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rmid_timeout: got busy want idle"); end
    n_checks++; if (obs_g.size() == 0 || obs_g[0] !== 2'b01) begin n_fail++; $display("FAIL rmid_tie: got %b want 01", obs_g.size() ? obs_g[0] : 2'bxx); end
    n_checks++; if (obs_d.size() != exp_d.size()) begin n_fail++; $display("FAIL rmid_len: got %0d want %0d", obs_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      n_checks++;
      if (obs_d[i] !== exp_d[i] || obs_g[i] !== exp_g[i]) begin
        n_fail++; $display("FAIL rmid_flit[%0d]: got g=%b d=%h want g=%b d=%h", i, obs_g[i], obs_d[i], exp_g[i], exp_d[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_back_to_back();
    test_single();
    test_size_zero();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
